// File: rtl/learn_mode_sequencer.sv
// Learn-mode song sequencer: walks the note ROM, presents each expected key
// to the key examiner, waits for a hit or a per-note timeout, then waits for
// the key to be released before moving on. Tallies hits and misses per song.
module learn_mode_sequencer #(
  parameter int          ADDR_W       = 4,
  parameter logic [27:0] NOTE_TIMEOUT = 28'd200_000_000,
  parameter logic [3:0]  END_NOTE     = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [3:0]        song_note,
  input  logic [3:0]        key_in,
  input  logic              correct_key_press,
  output logic [3:0]        correct_key,
  output logic              busy,
  output logic              done,
  output logic              note_hit,
  output logic              note_miss,
  output logic [ADDR_W:0]   hit_count,
  output logic [ADDR_W:0]   miss_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE    = 1;
  localparam logic [27:0]       TIMER_ONE  = 28'd1;
  localparam logic [27:0]       TIMER_LAST = NOTE_TIMEOUT - TIMER_ONE;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [3:0]        key_n;
  logic [27:0]       timer, timer_n;
  logic [ADDR_W:0]   hit_cnt_n, miss_cnt_n;
  logic              done_n, hit_n, miss_n;

  // busy is a pure decode of the song-playing states
  assign busy = (state == LOAD) || (state == WAIT_PRESS) || (state == WAIT_RELEASE);

  // Next-state and next-register values; abort outranks hit/miss in busy states
  always_comb begin
    state_n    = state;
    addr_n     = note_addr;
    key_n      = correct_key;
    timer_n    = timer;
    hit_cnt_n  = hit_count;
    miss_cnt_n = miss_count;
    done_n     = 1'b0;
    hit_n      = 1'b0;
    miss_n     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = LOAD;
          addr_n     = '0;
          hit_cnt_n  = '0;
          miss_cnt_n = '0;
        end
      end
      LOAD: begin
        if (abort || (song_note == END_NOTE)) begin
          state_n = DONE;
          done_n  = 1'b1;
          key_n   = END_NOTE;
        end else begin
          state_n = WAIT_PRESS;
          key_n   = song_note;
          timer_n = '0;
        end
      end
      WAIT_PRESS: begin
        if (abort) begin
          state_n = DONE;
          done_n  = 1'b1;
          key_n   = END_NOTE;
        end else if (correct_key_press) begin
          state_n   = WAIT_RELEASE;
          hit_n     = 1'b1;
          hit_cnt_n = hit_count + CNT_ONE;
          key_n     = END_NOTE;
        end else if (timer == TIMER_LAST) begin
          state_n    = WAIT_RELEASE;
          miss_n     = 1'b1;
          miss_cnt_n = miss_count + CNT_ONE;
          key_n      = END_NOTE;
        end else begin
          timer_n = timer + TIMER_ONE;
        end
      end
      WAIT_RELEASE: begin
        key_n = END_NOTE;
        if (abort) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (key_in == END_NOTE) begin
          if (note_addr == ADDR_LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = LOAD;
            addr_n  = note_addr + ADDR_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      note_addr   <= '0;
      correct_key <= END_NOTE;
      timer       <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      done        <= 1'b0;
      note_hit    <= 1'b0;
      note_miss   <= 1'b0;
    end else begin
      state       <= state_n;
      note_addr   <= addr_n;
      correct_key <= key_n;
      timer       <= timer_n;
      hit_count   <= hit_cnt_n;
      miss_count  <= miss_cnt_n;
      done        <= done_n;
      note_hit    <= hit_n;
      note_miss   <= miss_n;
    end
  end

endmodule
